// File: rtl/xgmii_start_align.sv
// rtl/xgmii_start_align.sv - moves each frame's /S/ into lane 0 with fixed two-cycle latency
module xgmii_start_align #(
  parameter int LANES = 8,
  parameter int ALIGN = 4,
  parameter int CNT_W = 32
) (
  input  logic                 xgmii_clk,
  input  logic                 sys_rst,
  input  logic [LANES-1:0]     in_rxc,
  input  logic [8*LANES-1:0]   in_rxd,
  output logic [LANES-1:0]     out_rxc,
  output logic [8*LANES-1:0]   out_rxd,
  output logic [CNT_W-1:0]     start_cnt,
  output logic [CNT_W-1:0]     realign_cnt,
  output logic [CNT_W-1:0]     err_cnt
);

  localparam int SW   = $clog2(LANES);
  localparam int EW   = $clog2(LANES + 1);
  localparam int SUMW = ((CNT_W > EW) ? CNT_W : EW) + 1;

  localparam logic [7:0]       IDLE    = 8'h07;
  localparam logic [7:0]       START   = 8'hFB;
  localparam logic [7:0]       ERR     = 8'hFE;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SW-1:0]      shift_q;
  logic [LANES-1:0]   r_rxc;
  logic [8*LANES-1:0] r_rxd;
  logic [LANES-1:0]   fix_rxc;
  logic [8*LANES-1:0] fix_rxd;
  logic               start_found;
  logic [SW-1:0]      start_lane;
  logic [EW-1:0]      bad_num;
  logic [LANES-1:0]   mix_rxc;
  logic [8*LANES-1:0] mix_rxd;

  // Saturating add: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [EW-1:0] b);
    logic [SUMW-1:0] s;
    s = SUMW'(a) + SUMW'(b);
    return (s > SUMW'(CNT_MAX)) ? CNT_MAX : CNT_W'(s);
  endfunction

  // Find the lowest aligned /S/ and turn every other /S/ into /E/.
  always_comb begin
    fix_rxc     = in_rxc;
    fix_rxd     = in_rxd;
    start_found = 1'b0;
    start_lane  = '0;
    bad_num     = '0;
    for (int i = 0; i < LANES; i++) begin
      if (in_rxc[i] && (in_rxd[8*i +: 8] == START)) begin
        if (((i % ALIGN) == 0) && !start_found) begin
          start_found = 1'b1;
          start_lane  = SW'(i);
        end else begin
          fix_rxd[8*i +: 8] = ERR;
          bad_num           = bad_num + EW'(1);
        end
      end
    end
  end

  // Build the output word from the stage register and the current word; when
  // the shift shrinks, current-word lanes from the new /S/ upward are idled
  // here because the next cycle emits them from the stage register.
  always_comb begin
    int src;
    int k;
    mix_rxc = '1;
    mix_rxd = {LANES{IDLE}};
    src     = 0;
    k       = 0;
    for (int j = 0; j < LANES; j++) begin
      src = j + int'(shift_q);
      if (src < LANES) begin
        mix_rxc[j]         = r_rxc[src];
        mix_rxd[8*j +: 8]  = r_rxd[8*src +: 8];
      end else begin
        k = src - LANES;
        if (start_found && (start_lane < shift_q) && (k >= int'(start_lane))) begin
          mix_rxc[j]        = 1'b1;
          mix_rxd[8*j +: 8] = IDLE;
        end else begin
          mix_rxc[j]        = fix_rxc[k];
          mix_rxd[8*j +: 8] = fix_rxd[8*k +: 8];
        end
      end
    end
  end

  // Datapath registers: stage word, output word and current shift.
  always_ff @(posedge xgmii_clk) begin
    if (sys_rst) begin
      out_rxc <= '1;
      out_rxd <= {LANES{IDLE}};
      r_rxc   <= '1;
      r_rxd   <= {LANES{IDLE}};
      shift_q <= '0;
    end else begin
      out_rxc <= mix_rxc;
      out_rxd <= mix_rxd;
      r_rxc   <= fix_rxc;
      r_rxd   <= fix_rxd;
      if (start_found) begin
        shift_q <= start_lane;
      end
    end
  end

  // Status counters.
  always_ff @(posedge xgmii_clk) begin
    if (sys_rst) begin
      start_cnt   <= '0;
      realign_cnt <= '0;
      err_cnt     <= '0;
    end else begin
      start_cnt   <= sat_add(start_cnt, EW'(start_found));
      realign_cnt <= sat_add(realign_cnt, EW'(start_found && (start_lane != shift_q)));
      err_cnt     <= sat_add(err_cnt, bad_num);
    end
  end

endmodule
